// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with run-time fixed-priority / round-robin selection.
// A hold-limit counter forces rotation when an owner keeps the grant with competitors pending.
module req_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rr_en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       last_q, last_d;

    logic [3:0] others;
    logic [1:0] win_any;
    logic [1:0] win_oth;
    logic       owner_req;

    // Fixed priority: highest index wins. Round-robin: first set bit at last+1, last+2, ...
    function automatic logic [1:0] pick(input logic [3:0] c, input logic rr,
                                        input logic [1:0] last);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        if (!rr) begin
            for (int i = 0; i < 4; i++) begin
                if (c[i]) w = 2'(i);
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = last + 2'(k) + 2'd1;
                if (c[idx]) w = idx;
            end
        end
        return w;
    endfunction

    assign others    = req & ~gnt_q;
    assign owner_req = |(req & gnt_q);
    assign win_any   = pick(req, rr_en, last_q);
    assign win_oth   = pick(others, rr_en, last_q);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BUSY;
                    gnt_d       = 4'b0001 << win_any;
                    gnt_id_d    = win_any;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    last_d      = win_any;
                end
            end
            BUSY: begin
                if (owner_req && (hold_cnt_q < HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (owner_req && !(|others)) begin
                    // Uncontested owner: counter saturates, grant kept indefinitely.
                    hold_cnt_d = hold_cnt_q;
                end else if (|others) begin
                    gnt_d       = 4'b0001 << win_oth;
                    gnt_id_d    = win_oth;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    last_d      = win_oth;
                    preempt_d   = owner_req;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    gnt_id_d    = 2'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_id_d    = 2'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_q      <= 2'd3;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4 with MAX_HOLD=4; expected values are hand-computed.
module tb_req_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rr_en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    req_arbiter_4 #(
        .MAX_HOLD(4),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rr_en    (rr_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                             input logic ev, input logic ep);
        check({tag, ".gnt"}, gnt, eg);
        check({tag, ".gnt_id"}, {2'b00, gnt_id}, {2'b00, eid});
        check({tag, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, ev});
        check({tag, ".preempt"}, {3'b000, preempt}, {3'b000, ep});
    endtask

    initial begin
        logic [3:0] exp_g;
        rst   = 1'b1;
        req   = 4'b0000;
        rr_en = 1'b0;
        #2;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fixed priority, then release handoff without a gap.
        req = 4'b1011;
        tick();
        check_all("fixed_first", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0011;
        tick();
        check_all("fixed_handoff", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check_all("fixed_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Uncontested hold beyond the limit.
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("uncont.gnt", gnt, 4'b0010);
            check("uncont.preempt", {3'b000, preempt}, 4'b0000);
        end
        req = 4'b0000;
        tick();
        check_all("uncont_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Round-robin on release: last=1, search order 2, 3, 0.
        rr_en = 1'b1;
        req   = 4'b0010;
        tick();
        check_all("rr_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1001;
        tick();
        check_all("rr_next3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0001;
        tick();
        check_all("rr_next0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Mode switch while owner 0 holds; fixed priority applies at the release decision.
        rr_en = 1'b0;
        tick();
        check_all("mode_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check_all("mode_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0110;
        tick();
        check_all("mode_release", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Asynchronous reset mid-grant.
        req = 4'b0100;
        tick();
        check_all("pre_reset", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        check_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0001;
        #3;
        rst = 1'b0;
        tick();
        check_all("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Round-robin rotation with hold limit from a fresh reset (last=3).
        req = 4'b0000;
        tick();
        rst = 1'b1;
        #2;
        rr_en = 1'b1;
        req   = 4'b1111;
        #3;
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                tick();
                check_all($sformatf("rot_g%0d_c%0d", g, c), exp_g, 2'(g % 4), 1'b1,
                          (g > 0) && (c == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
